sdram_rd_check: RTL and testbench

- Read-data checker sitting directly downstream of the SDRAM controller; consumes its rdata/rdata_vld stream, which is currently left open at top level.
- Snoops the read request handshake (rd_req/rd_ack/raddr) issued by the traffic generator and queues the burst start address.
- Compares every returned beat against the address-derived write pattern, then reports error count, first failing address and pass/done status for LED/debug use.

---
 rtl/sdram_chk_pkg.sv | 19 +
 rtl/sdram_chk_fifo.sv | 52 +++++
 rtl/sdram_rd_check.sv | 145 ++++++++++++++
 tb/tb_sdram_rd_check.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_chk_pkg.sv
// Shared definitions for the SDRAM read-data checker: default widths, FSM states
// and the address-to-data pattern also used by the traffic generator.
package sdram_chk_pkg;

    localparam int ADDR_W_DEF = 22;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Written and checked data both come from here so they cannot diverge.
    function automatic logic [15:0] sdram_pattern(input logic [ADDR_W_DEF-1:0] addr);
        return addr[15:0] ^ {10'b0, addr[21:16]};
    endfunction

endpackage

// File: rtl/sdram_chk_fifo.sv
// Synchronous FIFO holding outstanding burst start addresses; a pop frees the
// slot in the same cycle, so push+pop is accepted even when full.
module sdram_chk_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr[PTR_W-1:0]];

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
        end
    end

endmodule

// File: rtl/sdram_rd_check.sv
// SDRAM read-data checker: snoops acknowledged read requests, compares each returned
// beat against the address pattern. Optional `SDRAM_RD_CHECK_INJECT_EN adds an inject port.
module sdram_rd_check
    import sdram_chk_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int BURST_LEN   = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int TOTAL_BEATS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rd_req,
    input  logic              rd_ack,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rdata_vld,
`ifdef SDRAM_RD_CHECK_INJECT_EN
    input  logic              inject,
`endif
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data
);

    localparam int CNT_W  = $clog2(TOTAL_BEATS + 1);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_chk_cnt;
    logic [BEAT_W-1:0]   r_beat_idx;
    logic [15:0]         r_err_cnt;
    logic [ADDR_W-1:0]   r_first_err_addr;
    logic [DATA_W-1:0]   r_first_err_data;
    logic                r_overflow;
    logic                r_unexpected;

    logic                w_run;
    logic                w_start_run;
    logic                w_push;
    logic                w_beat;
    logic                w_pop;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [ADDR_W-1:0]   w_head;
    logic [ADDR_W-1:0]   w_beat_addr;
    logic [DATA_W-1:0]   w_expect;
    logic                w_mismatch;

    assign w_run       = (r_state == RUN);
    assign w_start_run = start && (r_state != RUN);
    assign w_push      = w_run && rd_req && rd_ack;
    assign w_beat      = w_run && rdata_vld;
    assign w_pop       = w_beat && !w_fifo_empty && (r_beat_idx == BEAT_W'(BURST_LEN - 1));
    assign w_beat_addr = w_fifo_empty ? '0 : w_head + ADDR_W'(r_beat_idx);

`ifdef SDRAM_RD_CHECK_INJECT_EN
    assign w_expect = DATA_W'(sdram_pattern(ADDR_W_DEF'(w_beat_addr))) ^ DATA_W'(inject);
`else
    assign w_expect = DATA_W'(sdram_pattern(ADDR_W_DEF'(w_beat_addr)));
`endif

    // A beat with no outstanding burst is always an error.
    assign w_mismatch = w_beat && (w_fifo_empty || (rdata != w_expect));

    sdram_chk_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_start_run),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (raddr),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // NOTE: default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_beat && (r_chk_cnt == CNT_W'(TOTAL_BEATS - 1))) w_state_nxt = DONE;
            DONE:    if (start) w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chk_cnt        <= '0;
            r_beat_idx       <= '0;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
            r_first_err_data <= '0;
            r_overflow       <= 1'b0;
            r_unexpected     <= 1'b0;
        end else if (w_start_run) begin
            r_chk_cnt        <= '0;
            r_beat_idx       <= '0;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
            r_first_err_data <= '0;
            r_overflow       <= 1'b0;
            r_unexpected     <= 1'b0;
        end else if (w_run) begin
            if (w_beat) begin
                r_chk_cnt <= r_chk_cnt + CNT_W'(1);
                if (w_fifo_empty)  r_unexpected <= 1'b1;
                else if (w_pop)    r_beat_idx   <= '0;
                else               r_beat_idx   <= r_beat_idx + BEAT_W'(1);
            end
            if (w_mismatch) begin
                if (r_err_cnt == 16'd0) begin
                    r_first_err_addr <= w_beat_addr;
                    r_first_err_data <= rdata;
                end
                if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
            end
            if (w_push && w_fifo_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    assign busy           = (r_state == RUN);
    assign done           = (r_state == DONE);
    assign pass           = done && (r_err_cnt == 16'd0) && !r_overflow && !r_unexpected;
    assign err_cnt        = r_err_cnt;
    assign first_err_addr = r_first_err_addr;
    assign first_err_data = r_first_err_data;

endmodule

// File: tb/tb_sdram_rd_check.sv
// Scoreboard bench for sdram_rd_check: a queue-based reference model predicts the
// status outputs after every cycle; a monitor compares them one cycle later.
module tb_sdram_rd_check;

    localparam int AW        = 22;
    localparam int DW        = 16;
    localparam int BL        = 4;
    localparam int FD        = 4;
    localparam int TB_BEATS  = 16;
    localparam int SAT_BEATS = 65540;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0, rd_req = 1'b0, rd_ack = 1'b0, rdata_vld = 1'b0;
    logic [AW-1:0] raddr = '0;
    logic [DW-1:0] rdata = '0;
    logic          busy, done, pass;
    logic [15:0]   err_cnt;
    logic [AW-1:0] first_err_addr;
    logic [DW-1:0] first_err_data;

    logic          s_start = 1'b0, s_vld = 1'b0;
    logic          s_busy, s_done, s_pass;
    logic [15:0]   s_err;
    logic [AW-1:0] s_faddr;
    logic [DW-1:0] s_fdata;

    always #5 clk = ~clk;

    sdram_rd_check #(
        .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .FIFO_DEPTH(FD), .TOTAL_BEATS(TB_BEATS)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .rd_req(rd_req), .rd_ack(rd_ack),
        .raddr(raddr), .rdata(rdata), .rdata_vld(rdata_vld),
`ifdef SDRAM_RD_CHECK_INJECT_EN
        .inject(1'b0),
`endif
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_err_addr(first_err_addr), .first_err_data(first_err_data)
    );

    sdram_rd_check #(
        .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .FIFO_DEPTH(FD), .TOTAL_BEATS(SAT_BEATS)
    ) u_sat (
        .clk(clk), .rst(rst), .start(s_start), .rd_req(1'b0), .rd_ack(1'b0),
        .raddr('0), .rdata(16'h5A5A), .rdata_vld(s_vld),
`ifdef SDRAM_RD_CHECK_INJECT_EN
        .inject(1'b0),
`endif
        .busy(s_busy), .done(s_done), .pass(s_pass), .err_cnt(s_err),
        .first_err_addr(s_faddr), .first_err_data(s_fdata)
    );

    typedef struct {
        int            due;
        logic          busy, done, pass;
        logic [15:0]   err;
        logic [AW-1:0] fa;
        logic [DW-1:0] fd;
    } exp_t;

    exp_t exp_q[$];
    int   ncyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state: outstanding bursts as a plain address queue.
    int          m_phase = 0;  // 0 idle, 1 running, 2 finished
    int unsigned m_q[$];
    int          m_pos, m_checks, m_err;
    int unsigned m_fa, m_fd;
    bit          m_ovf, m_unexp;

    function automatic logic [15:0] m_pat(int unsigned a);
        int unsigned v;
        v = (a % 65536) ^ (a / 65536);
        return v[15:0];
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_pos = 0; m_checks = 0; m_err = 0; m_fa = 0; m_fd = 0;
        m_ovf = 0; m_unexp = 0;
    endtask

    task automatic model_step(bit st, bit req, bit ack, int unsigned addr, bit vld, int unsigned data);
        bit mism, pop;
        int unsigned ba;
        if (st && m_phase != 1) begin
            model_clear();
            m_phase = 1;
            return;
        end
        if (m_phase != 1) return;
        mism = 0; pop = 0; ba = 0;
        if (vld) begin
            m_checks++;
            if (m_q.size() == 0) begin
                mism = 1;
                m_unexp = 1;
            end else begin
                ba = (m_q[0] + m_pos) % (1 << AW);
                mism = (data != m_pat(ba));
                m_pos++;
                if (m_pos == BL) begin
                    m_pos = 0;
                    pop = 1;
                end
            end
            if (mism) begin
                if (m_err == 0) begin
                    m_fa = ba;
                    m_fd = data;
                end
                if (m_err < 65535) m_err++;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (req && ack) begin
            if (m_q.size() < FD) m_q.push_back(addr);
            else                 m_ovf = 1;
        end
        if (m_checks == TB_BEATS) m_phase = 2;
    endtask

    task automatic drive(bit st, bit req, bit ack, logic [AW-1:0] addr, bit vld, logic [DW-1:0] data);
        exp_t e;
        @(negedge clk);
        #1;
        start = st; rd_req = req; rd_ack = ack; raddr = addr; rdata_vld = vld; rdata = data;
        model_step(st, req, ack, addr, vld, data);
        e.due  = ncyc + 1;
        e.busy = (m_phase == 1);
        e.done = (m_phase == 2);
        e.pass = (m_phase == 2) && (m_err == 0) && !m_ovf && !m_unexp;
        e.err  = m_err[15:0];
        e.fa   = AW'(m_fa);
        e.fd   = DW'(m_fd);
        exp_q.push_back(e);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, '0, 0, '0);
    endtask

    task automatic burst(logic [AW-1:0] a, int bad_beat, logic [DW-1:0] bad_data);
        logic [AW-1:0] ba;
        drive(0, 1, 1, a, 0, '0);
        for (int b = 0; b < BL; b++) begin
            ba = a + AW'(b);
            drive(0, 0, 0, '0, 1, (b == bad_beat) ? bad_data : m_pat(ba));
        end
    endtask

    task automatic good_beat();
        drive(0, 0, 0, '0, 1, m_pat((m_q[0] + m_pos) % (1 << AW)));
    endtask

    task automatic random_run(int err_pct);
        bit          vld, req, ack, pop, st;
        int unsigned d;
        for (int it = 0; it < 600 && m_phase == 1; it++) begin
            vld = (m_q.size() > 0) && ($urandom_range(0, 3) != 0);
            d   = vld ? m_pat((m_q[0] + m_pos) % (1 << AW)) : $urandom_range(0, 65535);
            if (vld && ($urandom_range(0, 99) < err_pct)) d = d ^ (32'd1 << $urandom_range(0, 15));
            pop = vld && (m_pos == BL - 1);
            req = ($urandom_range(0, 1) == 1);
            ack = ($urandom_range(0, 2) != 0) && ((m_q.size() < FD) || pop);
            st  = ($urandom_range(0, 15) == 0);
            drive(st, req, ack, AW'($urandom_range(0, (1 << AW) - 1)), vld, DW'(d));
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        exp_q.delete();
        rst = 1'b1;
        start = 0; rd_req = 0; rd_ack = 0; rdata_vld = 0; s_start = 0; s_vld = 0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_first_err_addr", 32'(first_err_addr), 0);
        chk("rst_first_err_data", 32'(first_err_data), 0);
        model_clear();
        m_phase = 0;
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Monitor: compares every prediction on the cycle the DUT output becomes visible.
    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        while (exp_q.size() > 0 && exp_q[0].due <= ncyc) begin
            e = exp_q.pop_front();
            vectors++;
            if (busy !== e.busy || done !== e.done || pass !== e.pass || err_cnt !== e.err ||
                first_err_addr !== e.fa || first_err_data !== e.fd) begin
                miscompares++;
                $display("FAIL status@cyc%0d: busy %b/%b done %b/%b pass %b/%b err_cnt %h/%h faddr %h/%h fdata %h/%h (got/expected)",
                         ncyc, busy, e.busy, done, e.done, pass, e.pass, err_cnt, e.err,
                         first_err_addr, e.fa, first_err_data, e.fd);
            end
        end
    end

    initial begin
        logic [AW-1:0] a5 [5];
        int            exp_sat;

        #5;
        do_reset();

        // Clean run over four consecutive bursts.
        drive(1, 0, 0, '0, 0, '0);
        for (int i = 0; i < 4; i++) burst(AW'(4 * i), -1, '0);
        idle(3);

        // Single corrupted beat in burst at 0x012340.
        drive(1, 0, 0, '0, 0, '0);
        burst(22'h012340, 2, 16'h0000);
        for (int i = 0; i < 3; i++) burst(AW'($urandom_range(0, (1 << AW) - 1)), -1, '0);
        idle(2);

        // Full FIFO with push and pop in the same cycle: nothing dropped.
        for (int i = 0; i < 5; i++) a5[i] = AW'($urandom_range(0, (1 << AW) - 1));
        drive(1, 0, 0, '0, 0, '0);
        for (int i = 0; i < 4; i++) drive(0, 1, 1, a5[i], 0, '0);
        for (int b = 0; b < BL; b++)
            drive(0, b == BL - 1, b == BL - 1, a5[4], 1, m_pat((a5[0] + b) % (1 << AW)));
        for (int i = 0; i < 12; i++) good_beat();
        idle(2);

        // Five acknowledged reads with no data: overflow.
        drive(1, 0, 0, '0, 0, '0);
        for (int i = 0; i < 5; i++) drive(0, 1, 1, AW'($urandom_range(0, (1 << AW) - 1)), 0, '0);
        for (int i = 0; i < 16; i++) good_beat();
        idle(2);

        // Read data with nothing outstanding.
        drive(1, 0, 0, '0, 0, '0);
        drive(0, 0, 0, '0, 1, DW'($urandom_range(0, 65535)));
        random_run(0);
        idle(2);

        // Address wrap at the top of the space, then random traffic with errors.
        drive(1, 0, 0, '0, 0, '0);
        drive(0, 1, 1, 22'h3FFFFE, 0, '0);
        drive(0, 0, 0, '0, 1, 16'hFFC1);
        drive(0, 0, 0, '0, 1, 16'hFFC0);
        drive(0, 0, 0, '0, 1, 16'h0000);
        drive(0, 0, 0, '0, 1, 16'h0001);
        random_run(25);
        idle(2);

        // Reset in the middle of a burst, then a clean run.
        drive(1, 0, 0, '0, 0, '0);
        drive(0, 1, 1, 22'h000100, 0, '0);
        drive(0, 0, 0, '0, 1, m_pat(32'h100));
        drive(0, 0, 0, '0, 1, 16'hDEAD);
        idle(1);
        do_reset();
        drive(1, 0, 0, '0, 0, '0);
        random_run(0);
        idle(3);

        // Saturation on the second instance: only unexpected beats.
        @(negedge clk); #1; s_start = 1'b1;
        @(negedge clk); #1; s_start = 1'b0; s_vld = 1'b1;
        for (int n = 1; n <= 65537; n++) begin
            @(negedge clk); #1;
            if (n == 65534 || n == 65535 || n == 65537) begin
                exp_sat = (n > 65535) ? 65535 : n;
                chk("sat_err_cnt", 32'(s_err), 32'(exp_sat));
            end
        end
        s_vld = 1'b0;
        chk("sat_busy", 32'(s_busy), 1);
        chk("sat_first_err_addr", 32'(s_faddr), 0);
        chk("sat_first_err_data", 32'(s_fdata), 32'h5A5A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
